// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequences one 8-point FFT through a register-mapped engine.
// It streams 16 input words into the X buffers, kicks and clears the GPR start bit,
// waits for completion with a timeout, then reads 16 result words out to a stream.
`timescale 1ns/1ps
module fft_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int GPR_ADDR   = 0,
  parameter int XR_BASE    = 31,
  parameter int XI_BASE    = 39,
  parameter int YR_BASE    = 47,
  parameter int YI_BASE    = 55,
  parameter int START_BIT  = 6,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] gpr_cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [DATA_WIDTH-1:0] src_data_in,
  input  logic                  src_valid_in,
  output logic                  src_ready_out,
  output logic [DATA_WIDTH-1:0] dst_data_out,
  output logic                  dst_valid_out,
  input  logic                  dst_ready_in,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic                  host_write_en,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_grant,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_write_en,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  fft_done
);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] START_MASK = DATA_WIDTH'(1) << START_BIT;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, CLEAR, WAIT, RADDR, RDATA} state_t;

  state_t                state_q, state_d;
  logic [3:0]            k_q, k_d, j_q, j_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d, done_q, done_d;
  logic                  dv_q, dv_d, fseen_q, fseen_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  src_hs;

  // Ready/valid come only from state flops, so no valid->ready or ready->valid path.
  assign src_hs        = (state_q == LOAD) && src_valid_in;
  assign busy          = (state_q != IDLE);
  assign host_grant    = (state_q == IDLE);
  assign src_ready_out = (state_q == LOAD);
  assign dst_valid_out = dv_q;
  assign dst_data_out  = dout_q;
  assign done          = done_q;
  assign error         = err_q;

  // Next-state, counters and output-register updates.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    done_d  = 1'b0;
    dv_d    = dv_q;
    dout_d  = dout_q;
    fseen_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        k_d     = '0;
        err_d   = 1'b0;
      end
      LOAD: if (src_hs) begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) state_d = KICK;
      end
      KICK: state_d = CLEAR;
      CLEAR: begin
        state_d = WAIT;
        tmo_d   = '0;
        // A completion that lands while the start bit is being cleared is not lost.
        fseen_d = fft_done;
      end
      WAIT: begin
        if (fft_done || fseen_q) begin
          state_d = RADDR;
          j_d     = '0;
        end else begin
          if (int'(tmo_q) < TIMEOUT) tmo_d = tmo_q + 1'b1;
          // The counter reaching TIMEOUT on this edge ends the wait.
          if (int'(tmo_q) + 1 >= TIMEOUT) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RADDR: begin
        state_d = RDATA;
        dv_d    = 1'b0;
      end
      RDATA: begin
        // Read data for the RADDR address arrives in the first RDATA cycle.
        if (!dv_q) begin
          dout_d = bus_rdata;
          dv_d   = 1'b1;
        end else if (dst_ready_in) begin
          dv_d = 1'b0;
          j_d  = j_q + 4'd1;
          if (j_q == 4'd15) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus mux: host owns the bus in IDLE; otherwise only controller accesses, else zero.
  always_comb begin
    bus_addr     = '0;
    bus_write_en = 1'b0;
    bus_wdata    = '0;
    case (state_q)
      IDLE: begin
        bus_addr     = host_addr;
        bus_write_en = host_write_en;
        bus_wdata    = host_wdata;
      end
      LOAD: if (src_hs && !rst) begin
        bus_addr     = ADDR_WIDTH'(k_q[0] ? XI_BASE : XR_BASE) + ADDR_WIDTH'(k_q[3:1]);
        bus_write_en = 1'b1;
        bus_wdata    = src_data_in;
      end
      KICK: if (!rst) begin
        bus_addr     = ADDR_WIDTH'(GPR_ADDR);
        bus_write_en = 1'b1;
        bus_wdata    = gpr_cfg | START_MASK;
      end
      CLEAR: if (!rst) begin
        bus_addr     = ADDR_WIDTH'(GPR_ADDR);
        bus_write_en = 1'b1;
        bus_wdata    = gpr_cfg & ~START_MASK;
      end
      RADDR: bus_addr = ADDR_WIDTH'(j_q[0] ? YI_BASE : YR_BASE) + ADDR_WIDTH'(j_q[3:1]);
      default: ;
    endcase
  end

  // State and register file with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      j_q     <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      dv_q    <= 1'b0;
      fseen_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      done_q  <= done_d;
      dv_q    <= dv_d;
      fseen_q <= fseen_d;
      dout_q  <= dout_d;
    end
  end
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Testbench for fft_seq_ctrl: table of host pass-through vectors, then scoreboarded
// transforms (nominal, backpressure, reset mid-load, timeout on a short-timeout copy).
`timescale 1ns/1ps
module tb_fft_seq_ctrl;
  localparam int DW = 16, AW = 6;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, fft_done = 1'b0;
  logic [DW-1:0] gpr_cfg = '0, src_data_in = '0, host_wdata = '0;
  logic src_valid_in = 1'b0, dst_ready_in = 1'b1, host_write_en = 1'b0;
  logic [AW-1:0] host_addr = '0;

  logic busy, done, error, src_ready_out, dst_valid_out, host_grant, bus_write_en;
  logic [DW-1:0] dst_data_out, bus_wdata, bus_rdata = '0;
  logic [AW-1:0] bus_addr;

  logic to_busy, to_done, to_error, to_src_ready, to_dst_valid, to_grant, to_we;
  logic [DW-1:0] to_dout, to_wdata, to_rdata = '0;
  logic [AW-1:0] to_addr;

  fft_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .gpr_cfg(gpr_cfg), .busy(busy), .done(done),
    .error(error), .src_data_in(src_data_in), .src_valid_in(src_valid_in),
    .src_ready_out(src_ready_out), .dst_data_out(dst_data_out), .dst_valid_out(dst_valid_out),
    .dst_ready_in(dst_ready_in), .host_addr(host_addr), .host_write_en(host_write_en),
    .host_wdata(host_wdata), .host_grant(host_grant), .bus_addr(bus_addr),
    .bus_write_en(bus_write_en), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .fft_done(fft_done));

  fft_seq_ctrl #(.TIMEOUT(15)) dut_to (
    .clk(clk), .rst(rst), .start(start), .gpr_cfg(gpr_cfg), .busy(to_busy), .done(to_done),
    .error(to_error), .src_data_in(src_data_in), .src_valid_in(src_valid_in),
    .src_ready_out(to_src_ready), .dst_data_out(to_dout), .dst_valid_out(to_dst_valid),
    .dst_ready_in(dst_ready_in), .host_addr(host_addr), .host_write_en(host_write_en),
    .host_wdata(host_wdata), .host_grant(to_grant), .bus_addr(to_addr),
    .bus_write_en(to_we), .bus_wdata(to_wdata), .bus_rdata(to_rdata),
    .fft_done(fft_done));

  always #5 clk = ~clk;

  // Memory model: read data equals the address, one cycle after the address.
  always @(posedge clk) begin
    bus_rdata <= DW'(bus_addr);
    to_rdata  <= DW'(to_addr);
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t wq[$];
  logic [DW-1:0] oq[$];

  int total = 0, bad = 0, done_cnt = 0;
  logic hold_q = 1'b0;
  logic [DW-1:0] hold_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  function automatic logic [DW-1:0] word(input int k, input int mode);
    if (mode == 0) return (k % 2 == 1) ? 16'h0000 : 16'(k / 2 + 1);
    return 16'(32'h8000 + k * 32'h0911);
  endfunction

  // Scoreboard monitor: controller writes, output handshakes, hold stability, done pulses.
  always @(negedge clk) begin
    wr_t w;
    logic [DW-1:0] o;
    if (bus_write_en && !host_grant) begin
      if (wq.size() == 0) fail("wr_extra");
      else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(bus_addr), 32'(w.a));
        chk("wr_data", 32'(bus_wdata), 32'(w.d));
      end
    end
    if (rst) hold_q <= 1'b0;
    else begin
      if (dst_valid_out && dst_ready_in) begin
        if (oq.size() == 0) fail("out_extra");
        else begin
          o = oq.pop_front();
          chk("out_data", 32'(dst_data_out), 32'(o));
        end
      end
      if (hold_q) begin
        chk("hold_valid", 32'(dst_valid_out), 32'd1);
        chk("hold_data", 32'(dst_data_out), 32'(hold_d));
      end
      hold_q <= dst_valid_out && !dst_ready_in;
      hold_d <= dst_data_out;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_writes(input int n, input int mode, input logic [DW-1:0] cfg, input bit gpr);
    for (int k = 0; k < n; k++)
      wq.push_back('{a: AW'(((k % 2 == 1) ? 39 : 31) + k / 2), d: word(k, mode)});
    if (gpr) begin
      wq.push_back('{a: 6'd0, d: cfg | 16'h0040});
      wq.push_back('{a: 6'd0, d: cfg & ~16'h0040});
    end
  endtask

  task automatic feed(input int n, input int mode, input bit gap, input bit poke);
    int k = 0, cyc = 0;
    bit hs;
    while (k < n && cyc < 400) begin
      src_valid_in = gap ? cyc[0] : 1'b1;
      src_data_in  = word(k, mode);
      if (poke) begin host_addr = 6'd5; host_write_en = 1'b1; host_wdata = 16'h1234; end
      @(negedge clk);
      hs = src_valid_in && src_ready_out;
      if (poke && k == 2) chk("grant_load", 32'(host_grant), 32'd0);
      @(posedge clk); #1;
      if (hs) k++;
      cyc++;
    end
    src_valid_in = 1'b0;
    host_write_en = 1'b0;
    if (k < n) fail("feed_timeout");
  endtask

  task automatic run(input logic [DW-1:0] cfg, input int mode, input bit gap, input bit stall,
                     input bit ign, input bit poke);
    int base, j, cyc, st;
    bit hs;
    base = done_cnt;
    gpr_cfg = cfg;
    push_writes(16, mode, cfg, 1'b1);
    for (int i = 0; i < 16; i++) oq.push_back(DW'(((i % 2 == 1) ? 55 : 47) + i / 2));
    pulse_start();
    feed(16, mode, gap, poke);
    for (int c = 0; c < 20; c++) begin
      start = ign && (c == 10);
      @(negedge clk);
      if (c == 10) begin
        chk("wait_addr", 32'(bus_addr), 32'd0);
        chk("wait_we", 32'(bus_write_en), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    j = 0; cyc = 0; st = 0;
    while (j < 16 && cyc < 500) begin
      dst_ready_in = !(stall && j == 3 && st < 5);
      start = ign && (j == 6);
      @(negedge clk);
      hs = dst_valid_out && dst_ready_in;
      if (dst_valid_out && !dst_ready_in) st++;
      @(posedge clk); #1;
      if (hs) j++;
      cyc++;
    end
    start = 1'b0;
    dst_ready_in = 1'b1;
    if (j < 16) fail("rx_timeout");
    if (stall) chk("stall_cycles", 32'(st), 32'd5);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt - base), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("oq_empty", 32'(oq.size()), 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] ha; logic hwe; logic [DW-1:0] hwd;
    logic [AW-1:0] ea; logic ewe; logic [DW-1:0] ewd;
  } vec_t;
  vec_t tv[5];

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int base, to_dn;
    tv[0] = '{6'd5,  1'b1, 16'h1234, 6'd5,  1'b1, 16'h1234};
    tv[1] = '{6'd0,  1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000};
    tv[2] = '{6'd63, 1'b1, 16'hFFFF, 6'd63, 1'b1, 16'hFFFF};
    tv[3] = '{6'd31, 1'b0, 16'h8001, 6'd31, 1'b0, 16'h8001};
    tv[4] = '{6'd42, 1'b1, 16'h5A5A, 6'd42, 1'b1, 16'h5A5A};

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_src_ready", 32'(src_ready_out), 32'd0);
    chk("rst_dst_valid", 32'(dst_valid_out), 32'd0);
    chk("rst_dout", 32'(dst_data_out), 32'd0);
    chk("rst_grant", 32'(host_grant), 32'd1);
    chk("rst_bus_we", 32'(bus_write_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Host pass-through in IDLE
    foreach (tv[i]) begin
      host_addr = tv[i].ha; host_write_en = tv[i].hwe; host_wdata = tv[i].hwd;
      @(negedge clk);
      chk("idle_addr", 32'(bus_addr), 32'(tv[i].ea));
      chk("idle_we", 32'(bus_write_en), 32'(tv[i].ewe));
      chk("idle_wdata", 32'(bus_wdata), 32'(tv[i].ewd));
      chk("idle_grant", 32'(host_grant), 32'd1);
      @(posedge clk); #1;
    end
    host_write_en = 1'b0; host_addr = '0; host_wdata = '0;

    // Nominal transform
    run(16'h0021, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Backpressure both sides, ignored starts, host writes blocked during LOAD
    run(16'hA5C0, 1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset after 7 words
    base = done_cnt;
    gpr_cfg = 16'h0021;
    push_writes(7, 0, 16'h0021, 1'b0);
    pulse_start();
    feed(7, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(src_ready_out), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("rstmid_wq", 32'(wq.size()), 32'd0);
    chk("rstmid_done", 32'(done_cnt - base), 32'd0);
    run(16'h0021, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout on the TIMEOUT=15 instance (both instances run in lockstep)
    to_dn = 0;
    gpr_cfg = 16'h0003;
    push_writes(16, 1, 16'h0003, 1'b1);
    pulse_start();
    feed(16, 1, 1'b0, 1'b0);
    for (int n = 0; n <= 17; n++) begin
      @(negedge clk);
      if (to_done) to_dn++;
      if (n == 16) chk("to_err_early", 32'(to_error), 32'd0);
      if (n == 17) begin
        chk("to_err", 32'(to_error), 32'd1);
        chk("to_busy", 32'(to_busy), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk("to_no_done", 32'(to_dn), 32'd0);
    pulse_start();
    @(negedge clk);
    chk("to_err_clr", 32'(to_error), 32'd0);
    chk("to_restart", 32'(to_busy), 32'd1);
    chk("to_wq", 32'(wq.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    oq.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
